// File: rtl/grf_multiport.sv
// ---------------------------------------------------------------------------
// grf_multiport: general-purpose register file with NRD combinational read
// ports, one write port, optional write-to-read forwarding and a per-register
// pending-write scoreboard.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   we        in   write enable
//   waddr     in   [ADDR_W-1:0]      write address
//   wdata     in   [DATA_W-1:0]      write data
//   raddr     in   [NRD*ADDR_W-1:0]  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata     out  [NRD*DATA_W-1:0]  read data, port k at [k*DATA_W +: DATA_W]
//   iss_en    in   issue strobe, marks iss_addr pending
//   iss_addr  in   [ADDR_W-1:0]      destination of the issued instruction
//   busy      out  [NRD-1:0]         pending flag per read port
//   busy_cnt  out  [ADDR_W:0]        number of pending registers
// Register 0 is hard-wired to zero; writes and issues to it are dropped.
// ---------------------------------------------------------------------------
module grf_multiport #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 5,
    parameter int                 NRD     = 2,
    parameter int                 BYPASS  = 1,
    parameter logic [DATA_W-1:0]  GP_INIT = 32'h1800,
    parameter logic [DATA_W-1:0]  SP_INIT = 32'h2ffc
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic [NRD-1:0]          busy,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    // Population count of the scoreboard vector.
    function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              wr_act_s;
    logic              iss_act_s;

    assign wr_act_s  = we && (waddr != {ADDR_W{1'b0}});
    assign iss_act_s = iss_en && (iss_addr != {ADDR_W{1'b0}});

    // Scoreboard next state: clear on write first, then set on issue so a
    // newer producer to the same register keeps the bit pending.
    always_comb begin
        sb_d = sb_q;
        if (wr_act_s) begin
            sb_d[waddr] = 1'b0;
        end else begin
            sb_d = sb_d;
        end
        if (iss_act_s) begin
            sb_d[iss_addr] = 1'b1;
        end else begin
            sb_d = sb_d;
        end
        busy_cnt_d = popcount(sb_d);
    end

    // Register storage with reset-time initial values for gp and sp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 28) begin
                    regs_q[i] <= GP_INIT;
                end else if (i == 29) begin
                    regs_q[i] <= SP_INIT;
                end else begin
                    regs_q[i] <= {DATA_W{1'b0}};
                end
            end
        end else if (wr_act_s) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Scoreboard bits and their population count, updated on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q       <= {NREG{1'b0}};
            busy_cnt_q <= {(ADDR_W+1){1'b0}};
        end else begin
            sb_q       <= sb_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports: storage lookup with optional same-cycle forwarding of the
    // write data; busy is suppressed when that forwarding resolves the hazard.
    always_comb begin
        rdata = {(NRD*DATA_W){1'b0}};
        busy  = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if ((BYPASS != 0) && wr_act_s && (waddr == raddr[k*ADDR_W +: ADDR_W])) begin
                rdata[k*DATA_W +: DATA_W] = wdata;
                busy[k]                   = 1'b0;
            end else begin
                rdata[k*DATA_W +: DATA_W] = regs_q[raddr[k*ADDR_W +: ADDR_W]];
                busy[k]                   = sb_q[raddr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_grf_multiport.sv
// ---------------------------------------------------------------------------
// tb_grf_multiport: directed self-checking bench for grf_multiport. Two
// instances share all inputs: one with forwarding enabled, one without.
// ---------------------------------------------------------------------------
module tb_grf_multiport;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [63:0] rdata_nb;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [1:0]  busy;
    logic [1:0]  busy_nb;
    logic [5:0]  busy_cnt;
    logic [5:0]  busy_cnt_nb;

    int checks_cnt = 0;
    int errors_cnt = 0;

    grf_multiport u_dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    grf_multiport #(.BYPASS(0)) u_dut_nb (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata_nb),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy_nb),
        .busy_cnt (busy_cnt_nb)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        we       = 1'b0;
        waddr    = 5'd0;
        wdata    = 32'h0;
        raddr    = 10'd0;
        iss_en   = 1'b0;
        iss_addr = 5'd0;

        // Reset pulse and reset-state reads.
        tick();
        tick();
        reset = 1'b0;
        set_rd(5'd0, 5'd28);
        check_eq("rst_r0",   {32'h0, rdata[31:0]},  64'h0);
        check_eq("rst_r28",  {32'h0, rdata[63:32]}, 64'h1800);
        set_rd(5'd29, 5'd5);
        check_eq("rst_r29",  {32'h0, rdata[31:0]},  64'h2ffc);
        check_eq("rst_r5",   {32'h0, rdata[63:32]}, 64'h0);
        check_eq("rst_busy", {62'h0, busy},         64'h0);
        check_eq("rst_cnt",  {58'h0, busy_cnt},     64'h0);

        // Write r8 while reading it: forwarded vs stored value.
        we = 1'b1; waddr = 5'd8; wdata = 32'hdeadbeef;
        set_rd(5'd8, 5'd8);
        check_eq("byp_r8",      {32'h0, rdata[31:0]},    64'hdeadbeef);
        check_eq("nobyp_r8_old", {32'h0, rdata_nb[31:0]}, 64'h0);
        tick();
        we = 1'b0;
        #1;
        check_eq("nobyp_r8_new", {32'h0, rdata_nb[31:0]}, 64'hdeadbeef);
        check_eq("r8_port0",     {32'h0, rdata[31:0]},    64'hdeadbeef);
        check_eq("r8_port1",     {32'h0, rdata[63:32]},   64'hdeadbeef);

        // Write to r0 is dropped, never forwarded.
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        set_rd(5'd0, 5'd0);
        check_eq("r0_wr_byp", {32'h0, rdata[31:0]}, 64'h0);
        tick();
        we = 1'b0;
        #1;
        check_eq("r0_after", {32'h0, rdata[31:0]}, 64'h0);
        check_eq("r0_cnt",   {58'h0, busy_cnt},    64'h0);

        // Issue r3, r4, r3 again, then write+issue r3 in one cycle.
        set_rd(5'd3, 5'd4);
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        check_eq("iss3_cnt", {58'h0, busy_cnt}, 64'd1);
        iss_addr = 5'd4;
        tick();
        check_eq("iss4_cnt", {58'h0, busy_cnt}, 64'd2);
        check_eq("iss4_busy", {62'h0, busy},    64'h3);
        iss_addr = 5'd3;
        tick();
        check_eq("reiss3_cnt", {58'h0, busy_cnt}, 64'd2);
        we = 1'b1; waddr = 5'd3; wdata = 32'h33;
        #1;
        check_eq("wr3_busy_byp",   {63'h0, busy[0]},    64'h0);
        check_eq("wr3_busy_nobyp", {63'h0, busy_nb[0]}, 64'h1);
        tick();
        we = 1'b0; iss_en = 1'b0;
        #1;
        check_eq("wriss3_cnt",  {58'h0, busy_cnt}, 64'd2);
        check_eq("wriss3_busy", {63'h0, busy[0]},  64'h1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h34;
        tick();
        we = 1'b0;
        #1;
        check_eq("wr3_cnt",  {58'h0, busy_cnt},     64'd1);
        check_eq("wr3_busy", {63'h0, busy[0]},      64'h0);
        check_eq("wr3_data", {32'h0, rdata[31:0]},  64'h34);
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        tick();
        we = 1'b0;
        #1;
        check_eq("wr4_cnt", {58'h0, busy_cnt}, 64'd0);

        // Issue r7 and write non-pending r9 together.
        set_rd(5'd7, 5'd9);
        iss_en = 1'b1; iss_addr = 5'd7;
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        tick();
        iss_en = 1'b0; we = 1'b0;
        #1;
        check_eq("iss7_busy", {62'h0, busy},         64'h1);
        check_eq("wr9_data",  {32'h0, rdata[63:32]}, 64'h99);
        check_eq("iss7_cnt",  {58'h0, busy_cnt},     64'd1);

        // Write+issue r10, issue r11, then reset between edges.
        iss_en = 1'b1; iss_addr = 5'd10;
        we = 1'b1; waddr = 5'd10; wdata = 32'haa;
        tick();
        we = 1'b0; iss_addr = 5'd11;
        tick();
        iss_en = 1'b0;
        set_rd(5'd10, 5'd11);
        check_eq("pre_rst_cnt",  {58'h0, busy_cnt},    64'd3);
        check_eq("pre_rst_busy", {62'h0, busy},        64'h3);
        check_eq("pre_rst_r10",  {32'h0, rdata[31:0]}, 64'haa);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_cnt",  {58'h0, busy_cnt},    64'd0);
        check_eq("mid_rst_busy", {62'h0, busy},        64'h0);
        check_eq("mid_rst_r10",  {32'h0, rdata[31:0]}, 64'h0);
        set_rd(5'd29, 5'd11);
        check_eq("mid_rst_r29",  {32'h0, rdata[31:0]}, 64'h2ffc);

        // Write and issue under reset are ignored across an edge.
        we = 1'b1; waddr = 5'd5; wdata = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd5;
        tick();
        we = 1'b0; iss_en = 1'b0;
        set_rd(5'd5, 5'd5);
        check_eq("rst_hold_cnt", {58'h0, busy_cnt},    64'd0);
        check_eq("rst_hold_r5",  {32'h0, rdata[31:0]}, 64'h0);

        // First edge after release works normally.
        reset = 1'b0;
        #1;
        iss_en = 1'b1; iss_addr = 5'd12;
        tick();
        iss_en = 1'b0;
        #1;
        check_eq("post_rst_cnt", {58'h0, busy_cnt}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/grf_multiport.md
GRF_MULTIPORT -- requirements
Module: grf_multiport

Interface
REQ-001 Parameter DATA_W, default 32: register and data width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; register count is 2**ADDR_W.
REQ-003 Parameter NRD, default 2: number of independent read ports, legal range 1..4.
REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-005 Parameter GP_INIT, default 32'h1800: reset value of register 28.
REQ-006 Parameter SP_INIT, default 32'h2ffc: reset value of register 29.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 we  in  1  write enable.
REQ-010 waddr  in  ADDR_W  write address.
REQ-011 wdata  in  DATA_W  write data.
REQ-012 raddr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-013 rdata  out  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-014 iss_en  in  1  issue strobe; marks register iss_addr as pending.
REQ-015 iss_addr  in  ADDR_W  destination register of the issued instruction.
REQ-016 busy  out  NRD  bit k high means register raddr[k] has a pending write not yet available.
REQ-017 busy_cnt  out  ADDR_W+1  number of registers currently marked pending.

Function
REQ-018 Register 0 SHALL read as 0 at all times; writes and issues to address 0 are ignored.
REQ-019 A write SHALL update register waddr with wdata at the rising clk edge when we=1 and waddr!=0.
REQ-020 Reads SHALL be combinational: rdata[k] = storage[raddr[k]], except under REQ-021.
REQ-021 With BYPASS=1, each port SHALL return wdata when we=1, waddr==raddr[k] and waddr!=0; with BYPASS=0, it SHALL return the old stored value.
REQ-022 Each register SHALL have one scoreboard bit; iss_en=1 with iss_addr!=0 sets bit iss_addr at the edge.
REQ-023 A write (we=1, waddr!=0) SHALL clear the scoreboard bit of waddr at the edge.
REQ-024 When an issue and a write target the same register in one cycle, the set SHALL win, so the bit remains 1 because a newer producer is in flight.
REQ-025 Issue and write to different registers in one cycle SHALL both take effect.
REQ-026 busy[k] SHALL equal sb[raddr[k]] AND NOT (we AND waddr==raddr[k] AND BYPASS); it is always 0 for address 0.
REQ-027 busy_cnt SHALL equal the population count of the scoreboard bits and update in the same edge as the bits.
REQ-028 Re-issuing an already-pending register SHALL leave the bit at 1 and busy_cnt unchanged.
REQ-029 A write to a non-pending register SHALL leave busy_cnt unchanged.
REQ-030 Multiple read ports addressing the same register SHALL return identical data and busy values.

Reset
REQ-031 Asserting reset SHALL immediately, without waiting for a clock edge:
- set register 28 to GP_INIT;
- set register 29 to SP_INIT;
- set all other registers to 0;
- clear all scoreboard bits;
- set busy_cnt to 0.
REQ-032 While reset is high, we and iss_en SHALL be ignored; reset asserted mid-operation discards all pending state.
REQ-033 After deassertion, the first rising edge SHALL process we and iss_en normally.

Verification
REQ-034 Pulse reset, then read registers 0, 28, 29 and 5 -> 0, 32'h1800, 32'h2ffc, 0; busy=0; busy_cnt=0.
REQ-035 Write 32'hdeadbeef to r8, and in the same cycle read r8 on port 0 -> with BYPASS=1, rdata0=32'hdeadbeef in that cycle; with BYPASS=0, rdata0=0 that cycle and 32'hdeadbeef the next cycle.
REQ-036 Write 32'h1234 to r0, then read r0 -> 0; busy_cnt stays 0.
REQ-037 Issue r3, then r4, then r3 again; then write r3 with iss_en=1 and iss_addr=3 in the same cycle -> busy_cnt goes 1, 2, 2, 2; busy stays 1 for r3; a later plain write to r3 -> busy_cnt=1.
REQ-038 Issue r7 and write r9 in the same cycle with r9 non-pending, while reading r7 and r9 -> r7 busy next cycle; r9 holds the new data; busy_cnt=1.
REQ-039 Issue r10 and r11, then assert reset between clock edges -> busy_cnt=0 and all busy bits 0 immediately; r10=0; r29=32'h2ffc.
